// File: rtl/audio_serial_rx_if.sv
// audio_serial_rx_if: serial audio pins in, held sample and status out
interface audio_serial_rx_if #(parameter int A = 8);
  logic sck;
  logic sdi;
  logic ws;
  logic signed [A-1:0] audio;
  logic sample_valid;
  logic frame_err;
  logic mute;
  modport master(output sck, sdi, ws, input audio, sample_valid, frame_err, mute);
  modport slave(input sck, sdi, ws, output audio, sample_valid, frame_err, mute);
endinterface

// File: rtl/audio_serial_rx.sv
// audio_serial_rx: 3-wire serial audio receiver with frame check and loss-of-signal mute; PREEMPH_EN adds pre-emphasis
module audio_serial_rx #(
  parameter int A = 8,
  parameter int SYNC = 2,
  parameter int TIMEOUT_W = 16
) (
  input logic clk,
  input logic rst,
  audio_serial_rx_if.slave bus
);
  localparam int BW = $clog2(A + 2);
  typedef enum logic {MUTED, ACTIVE} state_t;
  state_t state, state_n;
  logic [SYNC-1:0] sck_s, sdi_s, ws_s;
  logic sck_d, ws_d, sck_rise, ws_rise, accept, to_hit;
  logic [A-1:0] shreg, shreg_n, audio, audio_n, x_out;
  logic [BW-1:0] bitcnt, bitcnt_n;
  logic [TIMEOUT_W-1:0] cnt, cnt_n, cnt_inc;
  logic mute, mute_n, sv, sv_n, fe, fe_n;
  assign sck_rise = sck_s[SYNC-1] & ~sck_d;
  assign ws_rise = ws_s[SYNC-1] & ~ws_d;
  assign accept = ws_rise && bitcnt == BW'(A);
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign to_hit = state == ACTIVE && !accept && &cnt_inc;
`ifdef PREEMPH_EN
  logic [A-1:0] x_prev;
  logic [A:0] diff;
  assign diff = {shreg[A-1], shreg} - {{2{x_prev[A-1]}}, x_prev[A-1:1]};
  // sign bits disagree only on overflow; clamp toward the sign of the true result
  assign x_out = diff[A] ^ diff[A-1] ? {diff[A], {(A-1){~diff[A]}}} : diff[A-1:0];
  always_ff @(posedge clk)
    if (rst || to_hit) x_prev <= '0;
    else if (accept) x_prev <= shreg;
`else
  assign x_out = shreg;
`endif
  always_comb begin
    shreg_n = shreg;
    bitcnt_n = bitcnt;
    if (ws_rise) bitcnt_n = '0;
    else if (sck_rise) begin
      shreg_n = {shreg[A-2:0], sdi_s[SYNC-1]};
      bitcnt_n = bitcnt == BW'(A + 1) ? bitcnt : bitcnt + 1'b1;
    end
    sv_n = accept;
    fe_n = ws_rise && !accept;
    state_n = accept ? ACTIVE : to_hit ? MUTED : state;
    cnt_n = accept ? '0 : state == ACTIVE ? cnt_inc : cnt;
    mute_n = accept ? 1'b0 : to_hit ? 1'b1 : mute;
    audio_n = accept ? x_out : to_hit ? '0 : audio;
  end
  always_ff @(posedge clk)
    if (rst) begin
      sck_s <= '0;
      sdi_s <= '0;
      ws_s <= '0;
      sck_d <= 1'b0;
      ws_d <= 1'b0;
      state <= MUTED;
      shreg <= '0;
      bitcnt <= '0;
      cnt <= '0;
      audio <= '0;
      mute <= 1'b1;
      sv <= 1'b0;
      fe <= 1'b0;
    end else begin
      sck_s <= {sck_s[SYNC-2:0], bus.sck};
      sdi_s <= {sdi_s[SYNC-2:0], bus.sdi};
      ws_s <= {ws_s[SYNC-2:0], bus.ws};
      sck_d <= sck_s[SYNC-1];
      ws_d <= ws_s[SYNC-1];
      state <= state_n;
      shreg <= shreg_n;
      bitcnt <= bitcnt_n;
      cnt <= cnt_n;
      audio <= audio_n;
      mute <= mute_n;
      sv <= sv_n;
      fe <= fe_n;
    end
  assign bus.audio = audio;
  assign bus.sample_valid = sv;
  assign bus.frame_err = fe;
  assign bus.mute = mute;
endmodule

// File: tb/tb_audio_serial_rx.sv
// tb_audio_serial_rx: scoreboard bench; main DUT default timeout, second DUT with TIMEOUT_W=4 for the mute check
module tb_audio_serial_rx;
  localparam int A = 8;
  localparam int SYNC = 2;
  logic clk = 0, rst = 1, sck = 0, sdi = 0, ws = 0;
  always #5 clk = ~clk;
  audio_serial_rx_if #(.A(A)) m_if();
  audio_serial_rx_if #(.A(A)) t_if();
  assign m_if.sck = sck;
  assign m_if.sdi = sdi;
  assign m_if.ws = ws;
  assign t_if.sck = sck;
  assign t_if.sdi = sdi;
  assign t_if.ws = ws;
  audio_serial_rx #(.A(A), .SYNC(SYNC)) u_main(.clk(clk), .rst(rst), .bus(m_if.slave));
  audio_serial_rx #(.A(A), .SYNC(SYNC), .TIMEOUT_W(4)) u_to(.clk(clk), .rst(rst), .bus(t_if.slave));
  logic [A-1:0] a_m, a_t, held;
  assign a_m = m_if.audio;
  assign a_t = t_if.audio;
  typedef struct packed {logic err; logic [A-1:0] audio;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && (m_if.sample_valid || m_if.frame_err)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb unexpected: valid=%0b err=%0b audio=%0h, nothing expected", m_if.sample_valid, m_if.frame_err, a_m);
      end else begin
        e = q.pop_front();
        chk("sb kind", 32'(m_if.frame_err), 32'(e.err));
        chk("sb audio", 32'(a_m), 32'(e.audio));
      end
    end
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = v[i];
      clks(2);
      sck = 1;
      clks(3);
      sck = 0;
      clks(2);
    end
  endtask
  task automatic ws_pulse();
    ws = 1;
    clks(4);
    ws = 0;
    clks(4);
  endtask
  task automatic frame(input logic [7:0] v, input logic [7:0] exp_a);
    q.push_back({1'b0, exp_a});
    held = exp_a;
    bits({8'h0, v}, 8);
    ws_pulse();
  endtask
  task automatic err_frame(input logic [15:0] v, input int n);
    q.push_back({1'b1, held});
    bits(v, n);
    ws_pulse();
  endtask
  task automatic do_reset();
    rst = 1;
    clks(2);
    rst = 0;
    held = '0;
    clks(2);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int k;
    held = '0;
    clks(2);
    chk("reset audio", 32'(a_m), 0);
    chk("reset mute", 32'(m_if.mute), 1);
    chk("reset sample_valid", 32'(m_if.sample_valid), 0);
    chk("reset frame_err", 32'(m_if.frame_err), 0);
    rst = 0;
    clks(2);
    bits(16'h5A, 8);
    q.push_back({1'b0, 8'h5A});
    held = 8'h5A;
    ws = 1;
    @(posedge clk);
    repeat (SYNC - 1) @(posedge clk);
    #1 chk("latency early valid", 32'(m_if.sample_valid), 0);
    @(posedge clk);
    #1 chk("latency valid", 32'(m_if.sample_valid), 1);
    chk("latency audio", 32'(a_m), 32'h5A);
    clks(3);
    ws = 0;
    clks(4);
    chk("mute after accept", 32'(m_if.mute), 0);
    err_frame(16'h35, 7);
    err_frame(16'h1A5, 9);
    chk("audio after errors", 32'(a_m), 32'h5A);
    bits(16'hF, 4);
    do_reset();
    chk("mid-frame reset audio", 32'(a_m), 0);
    chk("mid-frame reset mute", 32'(m_if.mute), 1);
    bits(16'hC3, 8);
    q.push_back({1'b0, 8'hC3});
    held = 8'hC3;
    sdi = 1;
    clks(2);
    sck = 1;
    ws = 1;
    clks(3);
    sck = 0;
    clks(1);
    ws = 0;
    clks(4);
    chk("audio after C3", 32'(a_m), 32'hC3);
`ifdef PREEMPH_EN
    frame(8'h5A, 8'h79);
`else
    frame(8'h5A, 8'h5A);
`endif
    do_reset();
    frame(8'd64, 8'd64);
`ifdef PREEMPH_EN
    frame(8'd64, 8'd32);
`else
    frame(8'd64, 8'd64);
`endif
    do_reset();
    frame(8'd127, 8'd127);
    frame(8'h80, 8'h80);
    chk("audio -128", 32'(a_m), 32'h80);
    do_reset();
    q.push_back({1'b0, 8'h10});
    held = 8'h10;
    bits(16'h10, 8);
    ws = 1;
    k = 0;
    while (!t_if.sample_valid && k < 20) begin
      @(posedge clk);
      #1 k++;
    end
    chk("to valid seen", 32'(t_if.sample_valid), 1);
    chk("to audio", 32'(a_t), 32'h10);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    ws = 0;
    chk("to mute at 14", 32'(t_if.mute), 0);
    @(posedge clk);
    #1 chk("to mute at 15", 32'(t_if.mute), 1);
    chk("to audio at 15", 32'(a_t), 0);
    clks(2);
`ifdef PREEMPH_EN
    frame(8'h20, 8'h18);
`else
    frame(8'h20, 8'h20);
`endif
    chk("to unmute", 32'(t_if.mute), 0);
    chk("to audio 20", 32'(a_t), 32'h20);
    clks(5);
    chk("sb drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
